// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types: per-mode porch/sync/polarity bundle and the standard modes.
package vga_timing_pkg;

  localparam int unsigned MODE_FIELD_W = 16;

  typedef struct packed {
    logic [MODE_FIELD_W-1:0] h_active;
    logic [MODE_FIELD_W-1:0] h_fp;
    logic [MODE_FIELD_W-1:0] h_sync;
    logic [MODE_FIELD_W-1:0] h_bp;
    logic [MODE_FIELD_W-1:0] v_active;
    logic [MODE_FIELD_W-1:0] v_fp;
    logic [MODE_FIELD_W-1:0] v_sync;
    logic [MODE_FIELD_W-1:0] v_bp;
    logic                    hs_pol;
    logic                    vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640x480_60 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
    hs_pol: 1'b0, vs_pol: 1'b0};

  localparam vga_mode_t MODE_800x600_60 = '{
    h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
    v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
    hs_pol: 1'b1, vs_pol: 1'b1};

  localparam vga_mode_t MODE_1024x768_60 = '{
    h_active: 16'd1024, h_fp: 16'd24, h_sync: 16'd136, h_bp: 16'd160,
    v_active: 16'd768,  v_fp: 16'd3,  v_sync: 16'd6,   v_bp: 16'd29,
    hs_pol: 1'b0, vs_pol: 1'b0};

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter with sync/blank/last flags
// registered from the next-state count so they line up with count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 8,
  parameter int unsigned FP     = 2,
  parameter int unsigned SYNC   = 2,
  parameter int unsigned BP     = 4,
  parameter bit          POL    = 1'b1,
  parameter int unsigned W      = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         blnk,
  output logic         last
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST_VAL   = W'(TOTAL - 1);
  localparam logic [W-1:0] ACTIVE_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_nxt;

  always_comb begin
    count_nxt = count;
    if (step) begin
      count_nxt = (count == LAST_VAL) ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= !POL;
      blnk  <= 1'b0;
      last  <= 1'b0;
    end else begin
      count <= count_nxt;
      blnk  <= (count_nxt >= ACTIVE_END);
      sync  <= ((count_nxt >= SYNC_START) && (count_nxt < SYNC_END)) ? POL : !POL;
      last  <= (count_nxt == LAST_VAL);
    end
  end

endmodule

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: h/v counters, sync/blank flags,
// frame/line strobes and a frame counter, all advancing on the pixel enable.
module vga_timing_param
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 32'(MODE_800x600_60.h_active),
  parameter int unsigned H_FP     = 32'(MODE_800x600_60.h_fp),
  parameter int unsigned H_SYNC   = 32'(MODE_800x600_60.h_sync),
  parameter int unsigned H_BP     = 32'(MODE_800x600_60.h_bp),
  parameter int unsigned V_ACTIVE = 32'(MODE_800x600_60.v_active),
  parameter int unsigned V_FP     = 32'(MODE_800x600_60.v_fp),
  parameter int unsigned V_SYNC   = 32'(MODE_800x600_60.v_sync),
  parameter int unsigned V_BP     = 32'(MODE_800x600_60.v_bp),
  parameter bit          HS_POL   = MODE_800x600_60.hs_pol,
  parameter bit          VS_POL   = MODE_800x600_60.vs_pol,
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned RGB_W    = 12,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic [RGB_W-1:0]   rgb,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

  // Reject modes that cannot be counted or have degenerate porch/sync regions.
  if (64'(H_TOTAL) > CNT_RANGE || 64'(V_TOTAL) > CNT_RANGE) begin : g_range_err
    $error("vga_timing_param: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_zero_err
    $error("vga_timing_param: porch and sync parameters must be non-zero");
  end

  logic h_last;
  logic v_last;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .W(CNT_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .step(en),
    .count(hcount), .sync(hsync), .blnk(hblnk), .last(h_last)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .W(CNT_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .step(en & h_last),
    .count(vcount), .sync(vsync), .blnk(vblnk), .last(v_last)
  );

  // Strobes are decodes of registered position qualified by the enable.
  assign eol = en & h_last;
  assign sof = en & h_last & v_last;
  assign rgb = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (sof) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: arithmetic reference model over enabled-edge count,
// table-driven small-mode vectors, random enable, and async reset corner cases.
module tb_vga_timing_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] s_h, s_v, n_h, n_v, d_h, d_v;
  logic s_hs, s_vs, s_hb, s_vb, s_sof, s_eol;
  logic n_hs, n_vs, n_hb, n_vb, n_sof, n_eol;
  logic d_hs, d_vs, d_hb, d_vb, d_sof, d_eol;
  logic [11:0] s_rgb, n_rgb, d_rgb;
  logic [1:0]  s_fc;
  logic [15:0] n_fc, d_fc;

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11), .RGB_W(12), .FRAME_W(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(s_h), .vcount(s_v),
    .hsync(s_hs), .vsync(s_vs), .hblnk(s_hb), .vblnk(s_vb), .rgb(s_rgb),
    .sof(s_sof), .eol(s_eol), .frame_cnt(s_fc)
  );

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11), .RGB_W(12), .FRAME_W(16)
  ) u_neg (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(n_h), .vcount(n_v),
    .hsync(n_hs), .vsync(n_vs), .hblnk(n_hb), .vblnk(n_vb), .rgb(n_rgb),
    .sof(n_sof), .eol(n_eol), .frame_cnt(n_fc)
  );

  vga_timing_param u_def (
    .clk(clk), .rst_n(rst_n), .en(en), .hcount(d_h), .vcount(d_v),
    .hsync(d_hs), .vsync(d_vs), .hblnk(d_hb), .vblnk(d_vb), .rgb(d_rgb),
    .sof(d_sof), .eol(d_eol), .frame_cnt(d_fc)
  );

  int total = 0;
  int passed = 0;
  longint n = 0;  // enabled clock edges since reset release

  typedef struct {
    int h, v;
    bit hs, vs, hb, vb, sof, eol;
    longint fc;
  } exp_t;

  // Expected bundle from the count of enabled edges, by plain arithmetic.
  function automatic exp_t model(longint k, int ha, int hf, int hsy, int hbp,
                                 int va, int vf, int vsy, int vbp,
                                 bit hpol, bit vpol, int fw, bit e);
    exp_t r;
    longint ht = ha + hf + hsy + hbp;
    longint vt = va + vf + vsy + vbp;
    r.h   = int'(k % ht);
    r.v   = int'((k / ht) % vt);
    r.hb  = (r.h >= ha);
    r.vb  = (r.v >= va);
    r.hs  = (r.h >= ha + hf && r.h < ha + hf + hsy) ? hpol : !hpol;
    r.vs  = (r.v >= va + vf && r.v < va + vf + vsy) ? vpol : !vpol;
    r.eol = e && (r.h == ht - 1);
    r.sof = r.eol && (r.v == vt - 1);
    r.fc  = (k / (ht * vt)) % (64'd1 << fw);
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (n=%0d t=%0t)", name, act, exp, n, $time);
  endtask

  task automatic check_all();
    exp_t es, ed;
    es = model(n, 8, 2, 2, 4, 4, 1, 1, 2, 1'b1, 1'b1, 2, en);
    chk("s_h", s_h, es.h);     chk("s_v", s_v, es.v);
    chk("s_hs", s_hs, es.hs);  chk("s_vs", s_vs, es.vs);
    chk("s_hb", s_hb, es.hb);  chk("s_vb", s_vb, es.vb);
    chk("s_sof", s_sof, es.sof); chk("s_eol", s_eol, es.eol);
    chk("s_fc", s_fc, es.fc);  chk("s_rgb", s_rgb, 0);
    es = model(n, 8, 2, 2, 4, 4, 1, 1, 2, 1'b0, 1'b0, 16, en);
    chk("n_h", n_h, es.h);     chk("n_v", n_v, es.v);
    chk("n_hs", n_hs, es.hs);  chk("n_vs", n_vs, es.vs);
    chk("n_sof", n_sof, es.sof); chk("n_fc", n_fc, es.fc);
    ed = model(n, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 16, en);
    chk("d_h", d_h, ed.h);     chk("d_v", d_v, ed.v);
    chk("d_hs", d_hs, ed.hs);  chk("d_vs", d_vs, ed.vs);
    chk("d_hb", d_hb, ed.hb);  chk("d_vb", d_vb, ed.vb);
    chk("d_eol", d_eol, ed.eol); chk("d_sof", d_sof, ed.sof);
    chk("d_fc", d_fc, ed.fc);
  endtask

  // Called at a negedge: apply en, check, take the posedge, return on next negedge.
  task automatic cycle(input logic e);
    en = e;
    #1;
    check_all();
    @(posedge clk);
    if (e && rst_n) n++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    n = 0;
    #1;
    check_all();
    chk("neg_rst_hsync", n_hs, 1);
    chk("neg_rst_vsync", n_vs, 1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int adv;          // enabled cycles to run before this check
    int h, v;
    bit hb, hs, vb, vs;
    int fc;
  } vec_t;

  vec_t vecs[$];
  longint en_cnt;
  longint start_n;
  int cyc;

  initial begin
    vecs.push_back('{0,   0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{7,   7, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,   8, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{2,  10, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{1,  11, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{1,  12, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{4,   0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{48,  0, 4, 0, 0, 1, 0, 0});
    vecs.push_back('{16,  0, 5, 0, 0, 1, 1, 0});
    vecs.push_back('{16,  0, 6, 0, 0, 1, 0, 0});
    vecs.push_back('{32,  0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{256, 0, 0, 0, 0, 0, 0, 3});
    vecs.push_back('{128, 0, 0, 0, 0, 0, 0, 0});

    do_reset();

    // Small mode with en held high, fixed expectations per table row.
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].adv; k++) cycle(1'b1);
      en = 1'b1;
      #1;
      chk("vec_h", s_h, vecs[i].h);   chk("vec_v", s_v, vecs[i].v);
      chk("vec_hb", s_hb, vecs[i].hb); chk("vec_hs", s_hs, vecs[i].hs);
      chk("vec_vb", s_vb, vecs[i].vb); chk("vec_vs", s_vs, vecs[i].vs);
      chk("vec_fc", s_fc, vecs[i].fc);
    end

    // Default mode: one full line of 1056 enabled edges lands at (0,1).
    do_reset();
    for (int k = 0; k < 1056; k++) cycle(1'b1);
    chk("def_line_h", d_h, 0);
    chk("def_line_v", d_v, 1);

    // Enable pattern 1,0,0,1: two small-mode frames need 256 enabled edges.
    do_reset();
    en_cnt = 0;
    cyc = 0;
    while (en_cnt < 256 && cyc < 2000) begin
      logic e;
      e = (cyc % 4 == 0) || (cyc % 4 == 3);
      cycle(e);
      if (e) en_cnt++;
      cyc++;
    end
    chk("pat_edges", en_cnt, 256);
    chk("pat_fc", s_fc, 2);
    chk("pat_h", s_h, 0);
    chk("pat_v", s_v, 0);

    // Random enable against the model.
    do_reset();
    for (int k = 0; k < 1500; k++) cycle(1'($urandom_range(0, 1)));

    // Async reset between edges at (6,3), then restart from (0,0).
    do_reset();
    for (int k = 0; k < 54; k++) cycle(1'b1);
    chk("pre_rst_h", s_h, 6);
    chk("pre_rst_v", s_v, 3);
    en = 1'b1;
    #2;
    rst_n = 1'b0;
    n = 0;
    #1;
    check_all();
    chk("async_h", s_h, 0);
    chk("async_v", s_v, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1);
    en = 1'b1;
    #1;
    chk("resume_h", s_h, 1);
    chk("resume_v", s_v, 0);
    for (int k = 0; k < 20; k++) cycle(1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_timing_param.md
# vga_timing_param

Parametrised VGA timing generator producing the hcount/vcount/sync/blanking bundle consumed by every drawing stage over the `vga_if` interface. Display mode, sync polarity and counter width are set by parameters. A pixel-clock enable allows generation from a faster system clock. The block also emits start-of-frame and end-of-line strobes and a frame counter for game-logic pacing. It sits at the head of the video pipeline, ahead of the background and sprite stages.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP / H_SYNC / H_BP, 40 / 128 / 88, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 600, visible lines per frame
- V_FP / V_SYNC / V_BP, 1 / 4 / 23, vertical porch and sync, in lines
- HS_POL / VS_POL, 1 / 1, sync active level (1 = active-high)
- CNT_W, 11, width of hcount and vcount
- RGB_W, 12, width of rgb
- FRAME_W, 16, width of frame_cnt
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  pixel enable; the counters advance only on clk edges where en=1
- hcount / vcount  out  CNT_W  current pixel position
- hsync / vsync  out  1  sync outputs at the configured polarity
- hblnk / vblnk  out  1  blanking flags, active-high
- rgb  out  RGB_W  constant 0 (blank canvas for downstream stages)
- sof  out  1  start-of-frame strobe
- eol  out  1  end-of-line strobe
- frame_cnt  out  FRAME_W  count of completed frames

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Default values are 1056 and 628.
- On each clk edge with en=1, hcount increments. At hcount = H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount = V_TOTAL-1 with hcount wrapping, vcount wraps to 0.
- With en=0, every output holds its value, and sof and eol are forced to 0.
- hblnk = (hcount ≥ H_ACTIVE). vblnk = (vcount ≥ V_ACTIVE).
- hsync is at its active level when H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC. vsync follows the same rule on vcount with the vertical parameters.
- eol = 1 when en=1 and hcount = H_TOTAL-1.
- sof = 1 when en=1 and hcount = H_TOTAL-1 and vcount = V_TOTAL-1. It marks the last pixel of the frame; the next enabled edge starts the new frame at (0,0).
- frame_cnt increments on every clk edge where sof=1. It wraps from 2^FRAME_W-1 to 0.
- Elaboration check: $error if H_TOTAL > 2^CNT_W, V_TOTAL > 2^CNT_W, or any porch/sync parameter is 0.

## Timing
- All outputs except sof and eol are registered and mutually consistent in every cycle. hsync, hblnk, vsync and vblnk always correspond to the hcount and vcount presented in the same cycle.
- The registered flags are computed from the next-state counter values. This gives no extra latency relative to the counters.
- sof and eol are combinational decodes of registered state AND en.
- Reset (asynchronous, active-low) values:
  - hcount = 0, vcount = 0, hblnk = 0, vblnk = 0, rgb = 0, frame_cnt = 0.
  - hsync = !HS_POL and vsync = !VS_POL (inactive levels).
  - sof = 0 and eol = 0, because they are gated by the counters.
- Reset asserted mid-frame clears the block immediately, with no clock required. The first enabled edge after release produces hcount = 1, vcount = 0.
- With en held at 1, the line period is H_TOTAL clk cycles and the frame period is H_TOTAL·V_TOTAL clk cycles.

## Structure
- Package `vga_timing_pkg`:
  - `vga_mode_t` struct holding the active, front-porch, sync and back-porch values plus polarity for one axis pair.
  - Constants MODE_640x480_60, MODE_800x600_60 and MODE_1024x768_60 for top-level instantiation.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical):
  - Parameters: ACTIVE, FP, SYNC, BP, POL, W.
  - Inputs: clk, rst_n, step.
  - Outputs: count, sync, blnk, last.
  - The horizontal instance's step is en. The vertical instance's step is en AND the horizontal instance's last.
- The top level adds sof, eol, frame_cnt and rgb.
- A top-level wrapper connects the outputs to `vga_if.out`, which uses CNT_W = 11 and RGB_W = 12.

## Test plan
- Small mode: H 8/2/2/4 (total 16), V 4/1/1/2 (total 8), en = 1.
  - After reset release, hcount runs 0..15 then wraps with vcount → 1.
  - hblnk is high for hcount 8..15.
  - hsync is high exactly for hcount 10..11.
- Same mode: vblnk is high for vcount 4..7, and vsync is high only on vcount 5.
  - sof pulses every 128 clocks, only at hcount = 15, vcount = 7.
  - frame_cnt = 3 after 384 clocks.
- HS_POL = 0 and VS_POL = 0: in reset, hsync = vsync = 1; with those polarities hsync = 0 only at hcount 10..11.
- en toggled 1,0,0,1 repeatedly: the counters advance only on en = 1 edges, and sof/eol are never high while en = 0. A 2-frame run takes 2·128 enabled edges.
- Assert rst_n asynchronously at hcount = 6, vcount = 3, between clock edges: all outputs go to their reset values before the next edge, and counting resumes from 0.
- FRAME_W = 2: frame_cnt goes 3 → 0 on the fourth sof. With default parameters, the line period is 1056 and the frame period is 663168 clocks.
